// File: rtl/speed_pi_controller.sv
// Speed PI loop: captures a measured/target speed pair, runs a 4-state error/integrate/output
// sequence to produce duty and direction, and drives an 8-bit PWM for the H-bridge enable.
module speed_pi_controller #(
  parameter int KP_SHIFT  = 1,
  parameter int KI_SHIFT  = 3,
  parameter int INT_LIMIT = 2040
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic       sample_valid,
  input  logic [7:0] measured_speed,
  input  logic [7:0] target_speed,
  output logic [7:0] duty,
  output logic       direction,
  output logic       pwm_out,
  output logic       update_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERROR,
    S_INTEGRATE,
    S_OUTPUT
  } state_t;

  localparam logic signed [15:0] LIM_P = 16'(INT_LIMIT);
  localparam logic signed [15:0] LIM_N = 16'(-INT_LIMIT);

  state_t state, state_nxt;

  logic signed [7:0]  tgt_q, meas_q;
  logic signed [8:0]  err_q, err_d;
  logic signed [15:0] integ_q, integ_sum, integ_clamped;
  logic signed [17:0] p_term, i_ext, i_term, u_val;
  logic        [17:0] u_mag;
  logic        [7:0]  duty_d;

  logic [7:0] pwm_cnt;
  logic [7:0] pwm_duty;

  // ---------------- control FSM ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (sample_valid) state_nxt = S_ERROR;
      S_ERROR:     state_nxt = S_INTEGRATE;
      S_INTEGRATE: state_nxt = S_OUTPUT;
      S_OUTPUT:    state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
    if (!enable) state_nxt = S_IDLE;
  end

  // ---------------- datapath arithmetic ----------------
  always_comb begin
    err_d     = {tgt_q[7], tgt_q} - {meas_q[7], meas_q};
    integ_sum = integ_q + {{7{err_q[8]}}, err_q};
    if (integ_sum > LIM_P)
      integ_clamped = LIM_P;
    else if (integ_sum < LIM_N)
      integ_clamped = LIM_N;
    else
      integ_clamped = integ_sum;
  end

  // Both shifts are on signed operands so >>> floors toward minus infinity.
  always_comb begin
    p_term = {{9{err_q[8]}}, err_q};
    p_term = p_term <<< KP_SHIFT;
    i_ext  = {{2{integ_q[15]}}, integ_q};
    i_term = i_ext >>> KI_SHIFT;
    u_val  = p_term + i_term;
    u_mag  = u_val[17] ? 18'(-u_val) : 18'(u_val);
    duty_d = (u_mag > 18'd255) ? 8'hFF : u_mag[7:0];
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= S_IDLE;
      tgt_q       <= '0;
      meas_q      <= '0;
      err_q       <= '0;
      integ_q     <= '0;
      duty        <= '0;
      direction   <= 1'b0;
      update_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      update_done <= 1'b0;
      if (!enable) begin
        // Abandon any computation; direction intentionally keeps its last value.
        integ_q <= '0;
        duty    <= '0;
      end else begin
        case (state)
          S_IDLE: if (sample_valid) begin
            tgt_q  <= target_speed;
            meas_q <= measured_speed;
          end
          S_ERROR:     err_q   <= err_d;
          S_INTEGRATE: integ_q <= integ_clamped;
          S_OUTPUT: begin
            duty        <= duty_d;
            direction   <= u_val[17];
            update_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- PWM ----------------
  // New duty is picked up only at the wrap so a period is never split.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pwm_cnt  <= '0;
      pwm_duty <= '0;
      pwm_out  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'hFF) pwm_duty <= duty;
      pwm_out <= (pwm_cnt < pwm_duty);
    end
  end

endmodule

// File: tb/tb_speed_pi_controller.sv
// Self-checking bench for speed_pi_controller: directed spec scenarios plus random samples
// checked against an integer-arithmetic PI model.
module tb_speed_pi_controller;

  localparam int KP  = 1;
  localparam int KI  = 3;
  localparam int LIM = 2040;

  logic       clock = 1'b0;
  logic       resetn, enable, sample_valid;
  logic [7:0] measured_speed, target_speed;
  logic [7:0] duty;
  logic       direction, pwm_out, update_done;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_integ = 0;
  int m_duty  = 0;
  int m_dir   = 0;

  speed_pi_controller #(.KP_SHIFT(KP), .KI_SHIFT(KI), .INT_LIMIT(LIM)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .sample_valid(sample_valid),
    .measured_speed(measured_speed), .target_speed(target_speed),
    .duty(duty), .direction(direction), .pwm_out(pwm_out), .update_done(update_done)
  );

  always #5 clock = ~clock;

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic void model_step(input int t, input int m);
    int e, u, mag;
    e = t - m;
    m_integ = m_integ + e;
    if (m_integ > LIM)  m_integ = LIM;
    if (m_integ < -LIM) m_integ = -LIM;
    u = e * (1 << KP) + floor_div(m_integ, 1 << KI);
    m_dir  = (u < 0) ? 1 : 0;
    mag    = (u < 0) ? -u : u;
    m_duty = (mag > 255) ? 255 : mag;
  endfunction

  function automatic void model_reset();
    m_integ = 0; m_duty = 0; m_dir = 0;
  endfunction

  // One accepted sample; checks update latency, pulse width and the resulting outputs.
  task automatic pulse_sample(input int t, input int m, input string tag);
    int cnt, at;
    @(negedge clock);
    target_speed = 8'(t); measured_speed = 8'(m); sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
    model_step(t, m);
    cnt = 0; at = -1;
    for (int i = 0; i < 6; i++) begin
      if (update_done) begin cnt++; if (at < 0) at = i; end
      if (i == 3) begin
        checks++;
        if (duty !== 8'(m_duty) || direction !== 1'(m_dir)) begin
          errors++;
          $display("FAIL %s outputs: duty=%0d dir=%0d expected duty=%0d dir=%0d",
                   tag, duty, direction, m_duty, m_dir);
        end
      end
      @(negedge clock);
    end
    checks++;
    if (cnt != 1 || at != 3) begin
      errors++;
      $display("FAIL %s update_done: pulses=%0d first_at=%0d expected pulses=1 at=3", tag, cnt, at);
    end
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    int bad;
    resetn = 1'b0; enable = 1'b1; sample_valid = 1'b0;
    target_speed = '0; measured_speed = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (duty !== 8'd0 || direction !== 1'b0 || pwm_out !== 1'b0 || update_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: duty=%0d dir=%0b pwm=%0b upd=%0b expected all 0",
               duty, direction, pwm_out, update_done);
    end
    resetn = 1'b1;
    model_reset();
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (update_done !== 1'b0 || duty !== 8'd0 || pwm_out !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet: %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_basic_step();
    pulse_sample(50, 30, "step1");
    checks++;
    if (duty !== 8'd42) begin errors++; $display("FAIL step1_const: duty=%0d expected 42", duty); end
    pulse_sample(50, 30, "step2");
    checks++;
    if (duty !== 8'd45) begin errors++; $display("FAIL step2_const: duty=%0d expected 45", duty); end
  endtask

  task automatic test_negative();
    apply_reset();
    pulse_sample(0, 100, "neg");
    checks++;
    if ($signed(dut.integ_q) != -100 || duty !== 8'd213 || direction !== 1'b1) begin
      errors++;
      $display("FAIL neg_const: integ=%0d duty=%0d dir=%0b expected -100 213 1",
               $signed(dut.integ_q), duty, direction);
    end
  endtask

  task automatic test_back_to_back();
    enable = 1'b0;
    @(negedge clock);
    enable = 1'b1;
    m_integ = 0; m_duty = 0;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clock);
      if (k > 0) begin
        checks++;
        if (update_done !== 1'b1 || duty !== 8'(m_duty) || duty !== 8'd255) begin
          errors++;
          $display("FAIL sat_upd%0d: upd=%0b duty=%0d expected 1 255", k, update_done, duty);
        end
      end
      if (k >= 8) begin
        checks++;
        if ($signed(dut.integ_q) != m_integ || m_integ != LIM) begin
          errors++;
          $display("FAIL sat_integ%0d: integ=%0d expected %0d", k, $signed(dut.integ_q), LIM);
        end
      end
      if (k == 9) break;
      target_speed = 8'(127); measured_speed = 8'(-128); sample_valid = 1'b1;
      model_step(127, -128);
      @(negedge clock);
      sample_valid = 1'b0;
      repeat (2) @(negedge clock);
    end
    repeat (3) @(negedge clock);
    pulse_sample(0, 1, "sat_unwind");
  endtask

  task automatic test_pwm_boundary();
    int hi, upd;
    logic prev;
    bit found;
    enable = 1'b0;
    @(negedge clock);
    enable = 1'b1;
    m_integ = 0; m_duty = 0;
    pulse_sample(0, 30, "pwm_d64");
    repeat (300) @(negedge clock);
    found = 1'b0; prev = pwm_out;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clock);
      if (!prev && pwm_out) found = 1'b1;
      prev = pwm_out;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL pwm_sync: no rising edge seen expected one"); end
    hi = 0;
    for (int i = 0; i < 256; i++) begin if (pwm_out) hi++; @(negedge clock); end
    checks++;
    if (hi != 64) begin errors++; $display("FAIL pwm_64: high=%0d expected 64", hi); end
    hi = 0; upd = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm_out) hi++;
      if (update_done) upd++;
      if (i == 95) begin
        target_speed = 8'(62); measured_speed = 8'(0); sample_valid = 1'b1;
      end else if (i == 96) sample_valid = 1'b0;
      @(negedge clock);
    end
    model_step(62, 0);
    checks++;
    if (hi != 64 || upd != 1 || duty !== 8'(m_duty) || m_duty != 128) begin
      errors++;
      $display("FAIL pwm_midperiod: high=%0d upd=%0d duty=%0d expected 64 1 128", hi, upd, duty);
    end
    hi = 0;
    for (int i = 0; i < 256; i++) begin if (pwm_out) hi++; @(negedge clock); end
    checks++;
    if (hi != m_duty) begin errors++; $display("FAIL pwm_128: high=%0d expected %0d", hi, m_duty); end
  endtask

  task automatic test_abort_ignore();
    int cnt;
    @(negedge clock);
    target_speed = 8'(10); measured_speed = 8'(0); sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0; enable = 1'b0;
    @(negedge clock);
    enable = 1'b1;
    m_integ = 0; m_duty = 0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin if (update_done) cnt++; @(negedge clock); end
    checks++;
    if (cnt != 0 || duty !== 8'd0 || $signed(dut.integ_q) != 0) begin
      errors++;
      $display("FAIL abort: upd=%0d duty=%0d integ=%0d expected 0 0 0", cnt, duty, $signed(dut.integ_q));
    end
    target_speed = 8'(20); measured_speed = 8'(5); sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
    @(negedge clock);
    target_speed = 8'(100); measured_speed = 8'(-100); sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
    model_step(20, 5);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin if (update_done) cnt++; @(negedge clock); end
    checks++;
    if (cnt != 1 || duty !== 8'(m_duty) || direction !== 1'(m_dir)) begin
      errors++;
      $display("FAIL ignore_busy: upd=%0d duty=%0d dir=%0b expected 1 %0d %0d",
               cnt, duty, direction, m_duty, m_dir);
    end
  endtask

  task automatic test_reset_midcalc();
    int cnt;
    @(negedge clock);
    target_speed = 8'(-90); measured_speed = 8'(90); sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0; resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    model_reset();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin if (update_done) cnt++; @(negedge clock); end
    checks++;
    if (cnt != 0 || duty !== 8'd0 || direction !== 1'b0 || $signed(dut.integ_q) != 0) begin
      errors++;
      $display("FAIL reset_midcalc: upd=%0d duty=%0d dir=%0b expected 0 0 0", cnt, duty, direction);
    end
  endtask

  task automatic test_random();
    int t, m;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        enable = 1'b1;
        m_integ = 0; m_duty = 0;
        checks++;
        if (duty !== 8'd0 || direction !== 1'(m_dir)) begin
          errors++;
          $display("FAIL rand_disable: duty=%0d dir=%0b expected 0 %0d", duty, direction, m_dir);
        end
      end
      t = int'($urandom_range(0, 255)) - 128;
      m = int'($urandom_range(0, 255)) - 128;
      pulse_sample(t, m, "rand");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_step();
    test_negative();
    test_back_to_back();
    test_pwm_boundary();
    test_abort_ignore();
    test_reset_midcalc();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/speed_pi_controller.md
# speed_pi_controller

Closed-loop motor speed stage directly downstream of the encoder speed decoder. It consumes the signed 8-bit measured speed each time the decoder's velocity register updates and compares it against a commanded target speed. A saturating PI law computes a duty magnitude and a direction bit, and a built-in 8-bit PWM generator drives the H-bridge enable.

## Interface
Parameters:
- KP_SHIFT, 1: proportional gain as left shift (Kp = 2^KP_SHIFT).
- KI_SHIFT, 3: integral gain as arithmetic right shift (Ki = 2^-KI_SHIFT).
- INT_LIMIT, 2040: symmetric clamp on integrator magnitude (±INT_LIMIT).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- enable  input  1  loop enable; low forces idle, integrator clear, duty 0.
- sample_valid  input  1  one-cycle strobe: measured_speed has just been updated.
- measured_speed  input  8  signed two's-complement speed from the decoder.
- target_speed  input  8  signed two's-complement commanded speed.
- duty  output  8  unsigned applied duty magnitude (0–255).
- direction  output  1  0 = forward (u ≥ 0), 1 = reverse (u < 0).
- pwm_out  output  1  PWM waveform, period 256 clocks.
- update_done  output  1  one-cycle pulse when duty/direction update.

## Operation
- Reset (resetn low at an edge): FSM→IDLE; integrator, error register, duty, direction, pwm counter, latched PWM duty, pwm_out, update_done all 0. Reset wins over every other input, including mid-computation.
- FSM states: IDLE → ERROR → INTEGRATE → OUTPUT → IDLE, one clock each.
  - IDLE: on sample_valid=1 and enable=1, capture target_speed and measured_speed, go ERROR. Otherwise stay.
  - ERROR: e = target − measured, 9-bit signed (range −255..+255), registered.
  - INTEGRATE: integ_next = integ + e in 16-bit signed; clamp to [−INT_LIMIT, +INT_LIMIT]; register.
  - OUTPUT: u = (e <<< KP_SHIFT) + (integ >>> KI_SHIFT), 18-bit signed, arithmetic shifts (right shift floors toward −∞). Register direction = sign(u), duty = min(|u|, 255). Pulse update_done. Return to IDLE.
- sample_valid while not in IDLE is ignored (no queueing).
- enable low in any state: next state IDLE, integrator → 0, duty → 0, direction held, no update_done pulse. Any computation in progress is abandoned.
- PWM: 8-bit free-running counter, 0..255, wraps to 0. The active duty is latched from the duty register when the counter equals 255, so it takes effect at count 0. pwm_out = (counter < active_duty), registered. Duty 0 gives constant low. Duty 255 gives high for 255 of 256 clocks.

## Timing
- sample_valid sampled at edge T (in IDLE). The error register is valid after T+1, the integrator after T+2, and duty, direction and update_done after T+3.
- Minimum spacing between accepted samples: 4 clocks. A strobe at T+4 is accepted.
- A duty change reaches pwm_out at the first counter wrap after the update, plus 1 clock for the pwm_out register.
- direction changes with duty at T+3, not at the PWM boundary.

## Test plan
- Reset then idle: hold resetn low 2 clocks, release. Required: duty=0, direction=0, pwm_out=0, update_done=0, and no update for 300 clocks without sample_valid.
- Basic positive step (defaults): target=50, measured=30, strobe. Required: at T+3 duty=42, direction=0, and update_done high exactly 1 clock. Repeat the same sample: integrator 40, duty=45.
- Negative error and floor shift: from reset, target=0, measured=100. Required: e=−100, integrator −100, u=−200+(−13)=−213, so duty=213 and direction=1.
- Saturation: target=127, measured=−128, 9 strobes spaced 4 clocks apart. Required: duty=255 every update, integrator reaches 2040 on the 8th strobe and stays 2040 after the 9th.
- PWM and boundary: duty=64 steady. Required: pwm_out high for exactly 64 of each 256 clocks. Update duty to 128 while the counter is 100. Required: the current period still gives 64 high clocks and the next period gives 128.
- Abort and ignore: strobe, then enable=0 at T+1. Required: no update_done, duty=0, integrator 0. Also issue a strobe at T+2 during a valid computation. Required: the T+2 strobe is ignored and exactly one update_done occurs.
